// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: ALU-control
// operation codes, FSM state encoding, iteration count and a small
// conditional-negate helper.
package muldiv_pkg;

  localparam int ITER_CNT = 32;

  localparam logic [4:0] ALU_MUL    = 5'b10110;
  localparam logic [4:0] ALU_MULH   = 5'b10111;
  localparam logic [4:0] ALU_MULHSU = 5'b00001;
  localparam logic [4:0] ALU_MULHU  = 5'b00011;
  localparam logic [4:0] ALU_DIV    = 5'b11100;
  localparam logic [4:0] ALU_DIVU   = 5'b01100;
  localparam logic [4:0] ALU_REM    = 5'b00100;
  localparam logic [4:0] ALU_REMU   = 5'b11000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Two's-complement negate when n is set, pass-through otherwise.
  function automatic logic [31:0] neg_if(input logic n, input logic [31:0] v);
    return n ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_opdec.sv
// Combinational decode of the 5-bit ALU-control code into the attributes
// the multiply/divide datapath needs. want_hi_rem selects the upper product
// half for multiplies and the remainder for divides.
module muldiv_opdec
  import muldiv_pkg::*;
(
  input  logic [4:0] alusel,
  output logic       valid,
  output logic       is_div,
  output logic       want_hi_rem,
  output logic       a_signed,
  output logic       b_signed
);

  // Table decode; any unlisted code is reported as not valid.
  always_comb begin
    valid       = 1'b1;
    is_div      = 1'b0;
    want_hi_rem = 1'b0;
    a_signed    = 1'b0;
    b_signed    = 1'b0;
    case (alusel)
      // The low product half is sign-independent, so mul runs unsigned.
      ALU_MUL:    ;
      ALU_MULH:   begin want_hi_rem = 1'b1; a_signed = 1'b1; b_signed = 1'b1; end
      ALU_MULHSU: begin want_hi_rem = 1'b1; a_signed = 1'b1; end
      ALU_MULHU:  begin want_hi_rem = 1'b1; end
      ALU_DIV:    begin is_div = 1'b1; a_signed = 1'b1; b_signed = 1'b1; end
      ALU_DIVU:   begin is_div = 1'b1; end
      ALU_REM:    begin is_div = 1'b1; want_hi_rem = 1'b1; a_signed = 1'b1; b_signed = 1'b1; end
      ALU_REMU:   begin is_div = 1'b1; want_hi_rem = 1'b1; end
      default:    valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Operands are reduced to magnitudes
// at accept, 32 shift-add (multiply) or restoring (divide) steps run in
// CALC, FIX applies sign correction or the special-case value and writes
// result, DONE pulses done for one cycle.
// Optional feature macro: MULDIV_EARLY_OUT_EN -- divide-by-zero, signed
// divide overflow and multiply by zero go straight from IDLE to FIX.
//
// Handshake: start is sampled only while idle; an accepted op raises busy
// from the next cycle until FIX, then done pulses and result holds until
// the next operation's FIX. flush or rst return to IDLE without done.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [4:0]      alusel,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state
);

  logic dec_valid, dec_is_div, dec_hi_rem, dec_a_signed, dec_b_signed;

  muldiv_opdec u_opdec (
    .alusel      (alusel),
    .valid       (dec_valid),
    .is_div      (dec_is_div),
    .want_hi_rem (dec_hi_rem),
    .a_signed    (dec_a_signed),
    .b_signed    (dec_b_signed)
  );

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;
  // Multiply: {partial high, multiplier shifting out}.
  // Divide:   {partial remainder, dividend shifting out / quotient in}.
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN-1:0]   divisor_q, divisor_d;
  logic              is_div_q, is_div_d;
  logic              hi_rem_q, hi_rem_d;
  logic              neg_q, neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic              spec_q, spec_d;
  logic [XLEN-1:0]   spec_val_q, spec_val_d;

  // Accept-time operand conditioning and special-case detection.
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, mul_zero, skip_calc;
  logic [XLEN-1:0] spec_val;

  always_comb begin
    a_neg    = dec_a_signed & op_a[XLEN-1];
    b_neg    = dec_b_signed & op_b[XLEN-1];
    a_mag    = neg_if(a_neg, op_a);
    b_mag    = neg_if(b_neg, op_b);
    div_zero = dec_is_div & (op_b == '0);
    div_ovf  = dec_is_div & dec_a_signed & (op_a == 32'h8000_0000) & (op_b == 32'hFFFF_FFFF);
    mul_zero = ~dec_is_div & ((op_a == '0) | (op_b == '0));
    if (div_zero)     spec_val = dec_hi_rem ? op_a : 32'hFFFF_FFFF;
    else if (div_ovf) spec_val = dec_hi_rem ? 32'h0 : 32'h8000_0000;
    else              spec_val = '0;
`ifdef MULDIV_EARLY_OUT_EN
    skip_calc = div_zero | div_ovf | mul_zero;
`else
    skip_calc = 1'b0;
`endif
  end

  // One iteration step of each algorithm, plus the FIX-stage result select.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_trial, div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] mul_full;
  logic [XLEN-1:0]   mul_res, div_res;

  always_comb begin
    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, divisor_q} : '0);
    mul_next  = {mul_sum, prod_q[XLEN-1:1]};
    div_trial = prod_q[2*XLEN-1:XLEN-1];
    div_diff  = div_trial - {1'b0, divisor_q};
    if (div_trial >= {1'b0, divisor_q})
      div_next = {div_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
    else
      div_next = {prod_q[2*XLEN-2:0], 1'b0};
    mul_full = neg_q ? (~prod_q + 64'd1) : prod_q;
    mul_res  = hi_rem_q ? mul_full[2*XLEN-1:XLEN] : mul_full[XLEN-1:0];
    div_res  = hi_rem_q ? neg_if(rem_neg_q, prod_q[2*XLEN-1:XLEN])
                        : neg_if(neg_q, prod_q[XLEN-1:0]);
  end

  // Next-state logic for the FSM and datapath; flush has top priority.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    prod_d     = prod_q;
    divisor_d  = divisor_q;
    is_div_d   = is_div_q;
    hi_rem_d   = hi_rem_q;
    neg_d      = neg_q;
    rem_neg_d  = rem_neg_q;
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
    if (flush) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && dec_valid) begin
            prod_d     = {{XLEN{1'b0}}, a_mag};
            divisor_d  = b_mag;
            is_div_d   = dec_is_div;
            hi_rem_d   = dec_hi_rem;
            neg_d      = a_neg ^ b_neg;
            rem_neg_d  = a_neg;
            spec_d     = div_zero | div_ovf | mul_zero;
            spec_val_d = spec_val;
            busy_d     = 1'b1;
            cnt_d      = 5'(ITER_CNT - 1);
            state_d    = skip_calc ? FIX : CALC;
          end
        end
        CALC: begin
          prod_d = is_div_q ? div_next : mul_next;
          if (cnt_q == '0) state_d = FIX;
          else             cnt_d   = cnt_q - 5'd1;
        end
        FIX: begin
          result_d = spec_q ? spec_val_q : (is_div_q ? div_res : mul_res);
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = DONE;
        end
        DONE: state_d = IDLE;
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // All state registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      prod_q     <= '0;
      divisor_q  <= '0;
      is_div_q   <= 1'b0;
      hi_rem_q   <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      prod_q     <= prod_d;
      divisor_q  <= divisor_d;
      is_div_q   <= is_div_d;
      hi_rem_q   <= hi_rem_d;
      neg_q      <= neg_d;
      rem_neg_q  <= rem_neg_d;
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M vectors with literal
// expectations, plus a cycle-level reference model (accept time, latency,
// expected result queue) compared against busy/done/result every cycle.
module tb_muldiv_unit;

  localparam logic [4:0] C_MUL    = 5'b10110;
  localparam logic [4:0] C_MULH   = 5'b10111;
  localparam logic [4:0] C_MULHSU = 5'b00001;
  localparam logic [4:0] C_MULHU  = 5'b00011;
  localparam logic [4:0] C_DIV    = 5'b11100;
  localparam logic [4:0] C_DIVU   = 5'b01100;
  localparam logic [4:0] C_REM    = 5'b00100;
  localparam logic [4:0] C_REMU   = 5'b11000;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [4:0]  alusel;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] result;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  muldiv_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .flush     (flush),
    .alusel    (alusel),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic bit code_ok(input logic [4:0] sel);
    return sel inside {C_MUL, C_MULH, C_MULHSU, C_MULHU, C_DIV, C_DIVU, C_REM, C_REMU};
  endfunction

  function automatic logic [31:0] ref_result(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    bit ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (sel)
      C_MUL:    begin p = ua * ub; return p[31:0]; end
      C_MULH:   begin p = sa * sb; return p[63:32]; end
      C_MULHSU: begin p = sa * ub; return p[63:32]; end
      C_MULHU:  begin p = ua * ub; return p[63:32]; end
      C_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      C_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      C_REM: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      C_REMU: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
      default: return 32'h0;
    endcase
  endfunction

  // Cycles from accept to the done pulse.
  function automatic int lat_of(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    bit is_d;
    is_d = sel inside {C_DIV, C_DIVU, C_REM, C_REMU};
    if (is_d && b == 0) return 2;
    if ((sel == C_DIV || sel == C_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    if (!is_d && (a == 0 || b == 0)) return 2;
`endif
    return 34;
  endfunction

  logic [31:0] exp_q[$];
  int          cyc = 0;
  int          t_prev;
  bit          m_active = 1'b0;
  int          m_acc = 0;
  int          m_end = 0;
  logic [31:0] m_res = '0;
  bit          exp_busy = 1'b0;
  bit          exp_done = 1'b0;

  // Model: sample inputs at each rising edge, derive expected outputs for
  // the cycle that follows.
  always @(posedge clk) begin
    t_prev = cyc;
    cyc    = cyc + 1;
    if (rst) begin
      m_active = 1'b0;
      m_res    = '0;
      exp_q.delete();
    end else if (flush) begin
      m_active = 1'b0;
      exp_q.delete();
    end else if ((!m_active || t_prev > m_end) && start && code_ok(alusel)) begin
      m_active = 1'b1;
      m_acc    = t_prev;
      m_end    = t_prev + lat_of(alusel, op_a, op_b);
      exp_q.push_back(ref_result(alusel, op_a, op_b));
    end
    exp_busy = m_active && (cyc > m_acc) && (cyc < m_end);
    exp_done = m_active && (cyc == m_end);
    if (exp_done && exp_q.size() > 0) m_res = exp_q.pop_front();
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%08h exp=%08h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc busy", {31'd0, busy}, {31'd0, exp_busy});
      check("cyc done", {31'd0, done}, {31'd0, exp_done});
      check("cyc result", result, m_res);
    end
  end

  // ---------------- drivers ----------------
  logic [31:0] last_res;

  task automatic launch(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; alusel = sel; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0; alusel = 5'($urandom_range(0, 31)); op_a = $urandom; op_b = $urandom;
  endtask

  // Called at the negedge of cycle T+k0; returns k of the done cycle or -1.
  task automatic wait_done(input int k0, output int k_seen);
    int k;
    k = k0;
    k_seen = -1;
    while (k_seen < 0 && k <= k0 + 70) begin
      if (done) k_seen = k;
      else begin
        @(negedge clk);
        k++;
      end
    end
  endtask

  task automatic run_op(input string name, input logic [4:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int ks;
    launch(sel, a, b);
    wait_done(1, ks);
    check({name, " latency"}, 32'(ks), 32'(lat));
    check({name, " result"}, result, exp);
    last_res = exp;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ks, nd;
    logic [4:0]  codes[8];
    logic [4:0]  sel;
    logic [31:0] ra, rb;
    codes = '{C_MUL, C_MULH, C_MULHSU, C_MULHU, C_DIV, C_DIVU, C_REM, C_REMU};

    rst = 1'b1; start = 1'b0; flush = 1'b0; alusel = '0; op_a = '0; op_b = '0;
    last_res = '0;

    // Pin the model against hand-computed values.
    check("model mul",    ref_result(C_MUL,    32'd7,          32'hFFFF_FFFD), 32'hFFFF_FFEB);
    check("model mulh",   ref_result(C_MULH,   32'h8000_0000,  32'h8000_0000), 32'h4000_0000);
    check("model mulhsu", ref_result(C_MULHSU, 32'hFFFF_FFFF,  32'd2),         32'hFFFF_FFFF);
    check("model rem",    ref_result(C_REM,    32'hFFFF_FFF9,  32'd2),         32'hFFFF_FFFF);

    repeat (3) @(negedge clk);
    check("reset busy",   {31'd0, busy}, 32'd0);
    check("reset done",   {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset state",  {30'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Main function vectors.
    run_op("mul",    C_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run_op("mulh",   C_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34);
    run_op("mulhu",  C_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run_op("mulhsu", C_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34);
    run_op("div",    C_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34);
    run_op("rem",    C_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34);
    run_op("divu",   C_DIVU,   32'd100,        32'd7,         32'd14,        34);
    run_op("remu",   C_REMU,   32'd100,        32'd7,         32'd2,         34);

    // Special cases.
    run_op("divu0",  C_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, lat_of(C_DIVU, 32'd5, 32'd0));
    run_op("rem0",   C_REM,  32'd5,         32'd0,         32'd5,         lat_of(C_REM, 32'd5, 32'd0));
    run_op("divovf", C_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,
           lat_of(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF));
    run_op("removf", C_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,
           lat_of(C_REM, 32'h8000_0000, 32'hFFFF_FFFF));
    run_op("mulzero", C_MUL, 32'd0,         32'h1234_5678, 32'd0,  lat_of(C_MUL, 32'd0, 32'h1234_5678));
    run_op("remu0",  C_REMU, 32'hDEAD_BEEF, 32'd0,         32'hDEAD_BEEF, lat_of(C_REMU, 32'hDEAD_BEEF, 32'd0));

    // Unsupported code (add) is ignored.
    @(negedge clk);
    start = 1'b1; alusel = 5'b00000; op_a = 32'd1; op_b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      check("ignored busy", {31'd0, busy}, 32'd0);
      check("ignored done", {31'd0, done}, 32'd0);
      @(negedge clk);
    end

    // start pulsed during CALC is ignored; exactly one done.
    launch(C_MULHU, 32'h0001_0000, 32'h0003_0000);
    repeat (4) @(negedge clk);
    start = 1'b1; alusel = C_DIVU; op_a = 32'd9; op_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(6, ks);
    check("calc start latency", 32'(ks), 32'd34);
    check("calc start result", result, 32'd3);
    last_res = 32'd3;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("calc start extra done", 32'(nd), 32'd0);

    // flush at T+10: idle at T+11, no done, result kept.
    launch(C_DIVU, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", {31'd0, busy}, 32'd0);
    check("flush result", result, last_res);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("flush no done", 32'(nd), 32'd0);
    check("flush result hold", result, last_res);

    // flush together with start in IDLE: nothing accepted.
    @(negedge clk);
    flush = 1'b1; start = 1'b1; alusel = C_MUL; op_a = 32'd2; op_b = 32'd3;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    nd = 0;
    repeat (40) begin
      if (busy || done) nd++;
      @(negedge clk);
    end
    check("flush+start ignored", 32'(nd), 32'd0);

    // rst at T+20: all outputs zero next cycle.
    launch(C_MUL, 32'd5, 32'd6);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst busy",   {31'd0, busy}, 32'd0);
    check("rst done",   {31'd0, done}, 32'd0);
    check("rst result", result, 32'd0);
    rst = 1'b0;

    // A few extra operand patterns checked against the model.
    for (int i = 0; i < 8; i++) begin
      sel = codes[$urandom_range(0, 7)];
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      run_op("mixed", sel, ra, rb, ref_result(sel, ra, rb), lat_of(sel, ra, rb));
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
